// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one op at a time.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a registered single-step 64-bit product.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       command,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_FIN} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_cmd;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic             w_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic             w_to_fix;
    logic [WIDTH-1:0] w_spec_val;
    logic [AW-1:0]    w_acc_init;
    logic [WIDTH-1:0] w_opb_init;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [AW-1:0]    w_acc_step;
    logic [WIDTH-1:0] w_fix_val;

    // Multiplies keep the product sign in r_neg; divides keep the quotient or remainder sign.
    function automatic logic [WIDTH-1:0] f_finalize(input logic [2:0] cmd, input logic neg,
                                                    input logic [AW-1:0] acc);
        logic [AW-1:0]    prod;
        logic [WIDTH-1:0] part;
        prod = neg ? -acc : acc;
        part = cmd[1] ? acc[AW-1:WIDTH] : acc[WIDTH-1:0];
        if (!cmd[2]) begin
            f_finalize = (cmd[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[AW-1:WIDTH];
        end else begin
            f_finalize = neg ? -part : part;
        end
    endfunction

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_FIN)) && start && !kill;

    always_comb begin
        w_a_sgn = in1[WIDTH-1] && ((command == 3'd1) || (command == 3'd2) ||
                                   (command == 3'd4) || (command == 3'd6));
        w_b_sgn = in2[WIDTH-1] && ((command == 3'd1) || (command == 3'd4) || (command == 3'd6));
        w_a_mag = w_a_sgn ? -in1 : in1;
        w_b_mag = w_b_sgn ? -in2 : in2;
        w_neg   = (command == 3'd6) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
    end

    always_comb begin
        w_div0     = command[2] && (in2 == '0);
        w_ovf      = command[2] && !command[0] && (in1 == SMIN) && (in2 == ONES);
        w_special  = w_div0 || w_ovf;
        w_spec_val = w_div0 ? (command[1] ? in1 : ONES) : (command[1] ? '0 : SMIN);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0] w_fa;
    logic signed [WIDTH:0] w_fb;
    logic        [AW-1:0]  w_fprod;

    always_comb begin
        w_fa    = {w_a_sgn, in1};
        w_fb    = {w_b_sgn, in2};
        w_fprod = AW'(w_fa) * AW'(w_fb);
    end

    assign w_to_fix = w_special || !command[2];
`else
    assign w_to_fix = w_special;
`endif

    // Multiply: multiplier in acc low half, multiplicand in r_opb. Divide: dividend low, divisor in r_opb.
    always_comb begin
        w_acc_init = {{WIDTH{1'b0}}, w_a_mag};
        w_opb_init = w_b_mag;
        if (!command[2]) begin
            w_acc_init = {{WIDTH{1'b0}}, w_b_mag};
            w_opb_init = w_a_mag;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!command[2]) begin
            w_acc_init = w_fprod;
            w_opb_init = '0;
        end
`endif
        if (w_special) begin
            w_acc_init = {{WIDTH{1'b0}}, w_spec_val};
            w_opb_init = '0;
        end
    end

    always_comb begin
        w_sum   = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, r_opb};
        w_trial = r_acc[AW-1:WIDTH-1] - {1'b0, r_opb};
        if (!r_cmd[2]) begin
            w_acc_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[AW-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_step = {r_acc[AW-2:0], 1'b0};
        end
    end

    assign w_fix_val = (!r_cmd[2] && (r_cmd[1:0] != 2'd0)) ? r_acc[AW-1:WIDTH] : r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (w_accept) begin
                    w_state_next = w_to_fix ? S_FIX : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (kill) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIX: begin
                w_state_next = kill ? S_IDLE : S_FIN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN, S_FIX: busy = 1'b1;
            S_FIN:        done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cmd <= command;
            r_neg <= w_neg;
            r_cnt <= CW'(WIDTH - 1);
            r_acc <= w_acc_init;
            r_opb <= w_opb_init;
        end else if (!kill) begin
            // Result is written on the edge into FIN so it is valid alongside done.
            if (r_state == S_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    r_result <= f_finalize(r_cmd, r_neg, w_acc_step);
                end
            end else if (r_state == S_FIX) begin
                r_result <= w_fix_val;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed spec cases, kill/reset/back-to-back sequences, random ops.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  command;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill),
        .in1(in1), .in2(in2), .command(command),
        .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    endtask

    // Reference: 64-bit integer arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && (b == 0 || ((op == 3'd4 || op == 3'd6) &&
                                      a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (op < 3'd4) return 2;
`endif
        return 33;
    endfunction

    task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int t);
        exp_t e;
        e.res = ref_model(op, a, b);
        e.due = t + lat(op, a, b);
        sb_q.push_back(e);
    endtask

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done);
        command = op;
        in1     = a;
        in2     = b;
        start   = 1'b1;
        if (expect_done) push_exp(op, a, b, cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done got=done want=no_done result=0x%0h cyc=%0d", result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    logic [2:0]  d_op [12] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
    logic [31:0] d_a  [12] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd100, 32'd100,
                               32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h9ABC_DEF0};

    initial begin
        int          t0;
        logic [31:0] saved;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          n;

        reset = 1'b1; start = 1'b0; kill = 1'b0; in1 = '0; in2 = '0; command = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("busy_t1", busy, 1);
        repeat (31) @(negedge clk);
        check("busy_t32", busy, 1);
        @(negedge clk);
        check("busy_t33", busy, 0);

        for (int i = 0; i < 12; i++) begin
            wait_idle();
            issue(d_op[i], d_a[i], d_b[i], 1'b1);
        end

        // kill together with start: nothing is accepted
        wait_idle();
        command = 3'd5; in1 = 32'd9; in2 = 32'd4; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", busy, 0);
        saved = result;

        // abort mid-divide, then resume with remu 9/4
        issue(3'd4, 32'h0012_3456, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", busy, 0);
        check("kill_result_held", result, saved);
        issue(3'd7, 32'd9, 32'd4, 1'b1);

        // start held high across two multiplies, with stray start pulses mid-run
        wait_idle();
        t0 = cyc;
        command = 3'd0; in1 = 32'd3; in2 = 32'd5; start = 1'b1;
        push_exp(3'd0, 32'd3, 32'd5, t0);
        push_exp(3'd0, 32'd6, 32'd6, t0 + 33);
        repeat (5) @(negedge clk);
        in1 = 32'd6; in2 = 32'd6;
        repeat (29) @(negedge clk);
        start = 1'b0;
        check("b2b_busy_t34", busy, 1);
        repeat (6) @(negedge clk);
        command = 3'd5; in1 = 32'd100; in2 = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        command = 3'd0; in1 = 32'd100; in2 = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset mid-operation
        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                3: begin ra = -($urandom_range(0, 300)); rb = $urandom_range(1, 20); end
                default: ;
            endcase
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rop, ra, rb, 1'b1);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU and comparator. It takes the same two operand buses the ALU receives and runs one multi-cycle operation at a time. It stalls the pipeline through `busy`. It hands a 32-bit result to the same EX/MEM result path that consumes `alu_out`.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only when unit idle (busy=0)
- kill  in  1  pipeline flush; aborts any in-flight op
- in1  in  32  operand rs1 (dividend / multiplicand)
- in2  in  32  operand rs2 (divisor / multiplier)
- command  in  3  op, equals funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- busy  out  1  op in flight; stall request to pipeline
- done  out  1  one-cycle pulse; result valid this cycle
- result  out  32  op result; held stable until next accepted start

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high; reset=1 at a rising edge forces state IDLE, busy=0, done=0, result=0, and clears all internal registers.
  - Reset mid-operation aborts the op; no done pulse is produced.
- States:
  - IDLE: accept when start=1 && kill=0.
    - Operands and command are latched.
    - Special case detected → FIX, otherwise → RUN with counter=WIDTH-1.
  - RUN:
    - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
    - counter decrements each cycle; at counter==0 → FIN.
  - FIX: special-case result loaded → FIN.
  - FIN:
    - Signs applied to the result; done=1 and result updated.
    - busy=0 in this same cycle; start accepted in FIN exactly as in IDLE, allowing back-to-back ops.
- busy=1 in RUN and FIX, 0 in IDLE and FIN.
- Latency (start sampled at edge ending cycle T):
  - Normal op: busy=1 in cycles T+1..T+32; done=1 at T+33.
  - Special case: busy=1 at T+1; done at T+2.
- start while busy: ignored, no effect on the in-flight op.
- kill:
  - Any state, returns to IDLE next edge; done suppressed; result keeps its prior value.
  - kill with start in the same cycle: kill wins, nothing accepted.
- Signed handling:
  - Operands are converted to magnitudes before iterating; negation is applied in FIN.
  - mul: low 32 bits of the product; sign-independent.
  - mulh: high 32 bits of signed×signed 64-bit product.
  - mulhsu: high 32 bits of signed in1 × unsigned in2.
  - mulhu: high 32 bits of the unsigned product.
  - div/rem: quotient truncates toward zero; remainder takes the sign of the dividend.
- Special cases, resolved through FIX:
  - Divide by zero: div/divu → 0xFFFFFFFF; rem/remu → in1.
  - Signed overflow, div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
- Multiply ops never enter FIX.
- Internal datapath: 64-bit accumulator / remainder-quotient register plus 32-bit operand register; no combinational 32×32 multiplier in the default build.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
  - Defined: all four multiply ops bypass RUN. A registered full 64-bit product (signed/unsigned per op) is computed into FIN; busy=1 at T+1, done at T+2. Divide behaviour is unchanged.
  - Undefined: multiplies are iterative as above, with done at T+33; no hardware multiplier is inferred.

Test Plan:
- mul in1=7, in2=0xFFFFFFFD (−3) → done at T+33, result=0xFFFFFFEB. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- mulh 0x80000000×0x80000000 → 0x40000000. mulhsu in1=0xFFFFFFFF, in2=0xFFFFFFFF → 0xFFFFFFFF.
- div in1=0xFFFFFFF9 (−7), in2=2 → 0xFFFFFFFD. rem on the same operands → 0xFFFFFFFF. divu 100/7 → 14. remu 100/7 → 2.
- divu 100/0 → done at T+2, result 0xFFFFFFFF. remu 100/0 → 100. div 0x80000000/0xFFFFFFFF → 0x80000000. rem on the same operands → 0.
- Abort and resume sequence:
  - start div at T; kill=1 at T+10 → busy=0 at T+11, no done pulse, result unchanged.
  - start remu 9/4 at T+11 → done at T+44, result=1.
- Back-to-back and ignored-start sequence:
  - start=1 held continuously with mul 3×5 then mul 6×6 → done pulses at T+33 (15) and T+66 (36).
  - start pulses asserted mid-RUN are ignored.
  - reset asserted at T+5 → busy=0, done=0, result=0 next cycle.
